// File: rtl/slice_arb_pkg.sv
// Shared types for the time-sliced round-robin arbiter.
package slice_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/Counter.sv
// Modulo-M up counter with enable; co flags the terminal count while enabled.
module Counter #(
   parameter int M = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic co
);

   localparam int W = (M > 1) ? $clog2(M) : 1;

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= (cnt_q == W'(M - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   assign co = en && (cnt_q == W'(M - 1));

endmodule

// File: rtl/slice_arbiter.sv
// Round-robin arbiter whose grants are capped at SLICE cycles each.
module slice_arbiter
   import slice_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int SLICE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 slice_end
);

   localparam int IW = $clog2(N);

   arb_state_e   state_q, state_d;
   logic [N-1:0] gnt_q, gnt_d;
   logic [IW-1:0] id_q, id_d;
   logic [IW-1:0] ptr_q, ptr_d;

   logic          found;
   logic [IW-1:0] pick;
   logic [IW-1:0] pick_nxt;
   logic [IW:0]   sum;
   logic          co;
   logic          end_grant;
   logic          new_grant;
   logic          cnt_rst;

   // First set request scanning ptr, ptr+1, ... modulo N.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_q} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         if (!found && req[sum[IW-1:0]]) begin
            found = 1'b1;
            pick  = sum[IW-1:0];
         end
      end
   end

   assign pick_nxt  = (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
   assign end_grant = (state_q == GRANT) && (!req[id_q] || co);
   assign new_grant = found && ((state_q == IDLE) || end_grant);
   assign cnt_rst   = rst || new_grant || end_grant;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      if (new_grant) begin
         state_d     = GRANT;
         gnt_d       = '0;
         gnt_d[pick] = 1'b1;
         id_d        = pick;
         ptr_d       = pick_nxt;
      end else if (end_grant) begin
         state_d = IDLE;
         gnt_d   = '0;
         id_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

   // Restarted on every grant change so each owner starts its slice at 0.
   Counter #(
      .M (SLICE)
   ) u_slice_cnt (
      .clk (clk),
      .rst (cnt_rst),
      .en  (busy),
      .co  (co)
   );

   assign gnt       = gnt_q;
   assign gnt_id    = id_q;
   assign busy      = (state_q == GRANT);
   assign slice_end = co;

endmodule

// File: tb/tb_slice_arbiter.sv
// Directed scoreboard bench for slice_arbiter with N=4, SLICE=4.
module tb_slice_arbiter;

   localparam int N  = 4;
   localparam int SL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'hF;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       slice_end;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] id;
      logic       b;
      logic       se;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   step  = 0;

   slice_arbiter #(
      .N     (N),
      .SLICE (SL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .busy      (busy),
      .slice_end (slice_end)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s step %0d: observed %0h expected %0h",
                tag, step, obs, exp);
      end
   endtask

   // Drive req/rst for one edge; expected outputs are those after that edge.
   task automatic cyc(input logic [3:0] r, input logic rs,
                      input logic [3:0] eg, input logic se);
      exp_t e;
      e.g  = eg;
      e.b  = |eg;
      e.se = se;
      e.id = '0;
      for (int i = 0; i < 4; i++) begin
         if (eg[i]) e.id = 2'(i);
      end
      sb.push_back(e);
      req = r;
      rst = rs;
      @(posedge clk);
      @(negedge clk);
      step++;
      e = sb.pop_front();
      chk("gnt",       {4'b0, gnt},       {4'b0, e.g});
      chk("gnt_id",    {6'b0, gnt_id},    {6'b0, e.id});
      chk("busy",      {7'b0, busy},      {7'b0, e.b});
      chk("slice_end", {7'b0, slice_end}, {7'b0, e.se});
   endtask

   initial begin
      @(negedge clk);
      // Reset held with all requesting
      cyc(4'hF, 1'b1, 4'b0000, 1'b0);
      cyc(4'hF, 1'b1, 4'b0000, 1'b0);

      // Rotation: first grant one cycle after reset falls, 4-cycle slices
      for (int s = 0; s < 5; s++) begin
         for (int c = 0; c < SL; c++) begin
            cyc(4'hF, 1'b0, 4'(1 << (s % 4)), (c == SL - 1));
         end
      end

      // Early release of owner 2 with req[0] waiting
      cyc(4'b0101, 1'b0, 4'b0100, 1'b0);
      cyc(4'b0101, 1'b0, 4'b0100, 1'b0);
      cyc(4'b0001, 1'b0, 4'b0001, 1'b0);

      // Lone requester 3: re-granted on expiry, pulse every 4 cycles
      for (int i = 0; i < 10; i++) begin
         cyc(4'b1000, 1'b0, 4'b1000, ((i % 4) == 3));
      end
      cyc(4'b1000, 1'b0, 4'b1000, 1'b0);
      cyc(4'b1000, 1'b0, 4'b1000, 1'b1);

      // Release coinciding with expiry, handover to requester 1
      cyc(4'b0010, 1'b0, 4'b0010, 1'b0);
      cyc(4'b0010, 1'b0, 4'b0010, 1'b0);
      cyc(4'b0010, 1'b0, 4'b0010, 1'b0);
      cyc(4'b0010, 1'b0, 4'b0010, 1'b1);
      // Release coinciding with expiry, nobody waiting -> IDLE
      cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
      cyc(4'b0000, 1'b0, 4'b0000, 1'b0);

      // Mid-grant reset, then pointer restarts at 0
      cyc(4'b0010, 1'b0, 4'b0010, 1'b0);
      cyc(4'b0010, 1'b0, 4'b0010, 1'b0);
      cyc(4'b0110, 1'b1, 4'b0000, 1'b0);
      cyc(4'b0110, 1'b0, 4'b0010, 1'b0);
      cyc(4'b0110, 1'b0, 4'b0010, 1'b0);
      cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
      cyc(4'b0000, 1'b0, 4'b0000, 1'b0);

      chk("sb_empty", 8'(sb.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/slice_arbiter.md
SLICE_ARBITER -- requirements
Module: slice_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, range 2..16.
REQ-002 SHALL have parameter SLICE, default 16: maximum grant length in cycles, SLICE >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port req, input, N: request per requester, level-sensitive.
REQ-006 SHALL have port gnt, output, N: one-hot grant, registered.
REQ-007 SHALL have port gnt_id, output, $clog2(N): index of current owner; valid while busy.
REQ-008 SHALL have port busy, output, 1: high while any gnt bit is high.
REQ-009 SHALL have port slice_end, output, 1: one-cycle pulse in the last cycle of an expiring slice.

Function
REQ-010 SHALL implement two states: IDLE (gnt = 0) and GRANT (exactly one gnt bit high).
REQ-011 SHALL hold a round-robin pointer ptr; the search order is ptr, ptr+1, ..., wrapping modulo N.
REQ-012 In IDLE with req != 0, SHALL enter GRANT at the next edge, granting the first set req bit in search order (1-cycle latency).
REQ-013 On every new grant to index k, SHALL set ptr to (k+1) mod N.
REQ-014 In GRANT, SHALL count owner cycles in a slice counter, 0..SLICE-1, starting at 0 in the first granted cycle.
REQ-015 Release: owner req low in a GRANT cycle SHALL end the grant at the next edge.
REQ-016 Expiry: slice counter == SLICE-1 with owner req still high SHALL end the grant at the next edge; slice_end high in that cycle only.
REQ-017 On grant end, if any other req bit is set, SHALL grant the next requester in search order at the same edge (no idle bubble); otherwise SHALL go to IDLE.
REQ-018 On expiry with only the owner requesting, SHALL re-grant the owner with the slice counter restarted at 0; ptr updates per REQ-013.
REQ-019 Release and expiry in the same cycle SHALL be treated as release; slice_end still pulses.
REQ-020 A requester SHALL never be granted twice while another req bit stays high continuously (starvation bound: (N-1)*SLICE cycles).
REQ-021 Req bits of non-owners SHALL NOT affect the current grant.
REQ-022 gnt_id SHALL equal the index of the set gnt bit; it SHALL be 0 in IDLE.

Reset
REQ-023 While rst is high at an edge: state = IDLE, gnt = 0, gnt_id = 0, busy = 0, ptr = 0, slice counter = 0, slice_end = 0.
REQ-024 rst asserted mid-grant SHALL drop gnt at that edge regardless of req; the first grant after rst falls follows REQ-012 with ptr = 0.

Structure
REQ-025 SHALL place the state enum (IDLE, GRANT) in a shared package, slice_arb_pkg.
REQ-026 SHALL instantiate the existing Counter module (M = SLICE) as the slice counter.
REQ-027 The Counter instance SHALL have en = busy and rst = rst | grant-change, and its co SHALL drive slice_end.
REQ-028 The arbiter SHALL use no other sub-modules; the priority search is combinational from req and ptr.

Verification
REQ-029 Reset: hold rst with req = 4'b1111 -> gnt = 0, busy = 0; release rst -> gnt = 4'b0001 one cycle later.
REQ-030 Rotation: N=4, SLICE=4, req = 4'b1111 constant -> gnt sequence 0001,0010,0100,1000,0001, each held 4 cycles, slice_end once per slice, no gap.
REQ-031 Early release: owner 2 drops req after 2 cycles with req[0] high -> gnt = 4'b0001 at the next edge, no slice_end.
REQ-032 Lone requester: only req[3] high for 10 cycles, SLICE=4 -> gnt[3] high continuously, slice_end at cycles 4 and 8.
REQ-033 Simultaneous release and expiry: owner drops req in cycle SLICE-1 -> slice_end = 1, next grant or IDLE per REQ-017.
REQ-034 Mid-grant reset: rst in cycle 2 of a grant to 1 -> gnt = 0 next edge; with req = 4'b0110 after rst, first grant = 4'b0010.
